spi_regbank: RTL

Register bank and data buffering downstream of the APB slave. It decodes the internal-bus write/read strobes into SPI control and status registers, and buffers transmit and receive bytes in two FIFOs. It also drives the configuration and byte-stream handshake into the SPI shift engine. It is the consumer of `waddr/wdata/wr_en/raddr/rd_en` and the producer of `rdata/wack/rack/waddrerr/raddrerr`.

---
 rtl/spi_regbank_pkg.sv | 34 +++
 rtl/spi_sync_fifo.sv | 57 +++++
 rtl/spi_regbank.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/spi_regbank_pkg.sv
// Shared definitions for the SPI register bank: register offsets, CTRL/STATUS bit
// positions and the CPU access state encoding.
package spi_regbank_pkg;

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_STATUS = 32'h04;
    localparam logic [31:0] OFF_CLKDIV = 32'h08;
    localparam logic [31:0] OFF_TXDATA = 32'h0C;
    localparam logic [31:0] OFF_RXDATA = 32'h10;
    localparam logic [31:0] OFF_LEVEL  = 32'h14;
    localparam logic [31:0] REG_WINDOW = 32'h18;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CPOL   = 1;
    localparam int CTRL_CPHA   = 2;
    localparam int CTRL_TXCLR  = 3;
    localparam int CTRL_RXCLR  = 4;
    localparam int CTRL_IRQ_EN = 8;

    localparam int STS_TX_FULL  = 0;
    localparam int STS_TX_EMPTY = 1;
    localparam int STS_RX_FULL  = 2;
    localparam int STS_RX_EMPTY = 3;
    localparam int STS_BUSY     = 4;
    localparam int STS_RX_OVF   = 5;
    localparam int STS_TX_OVF   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WACK = 2'd1,
        ST_RACK = 2'd2
    } acc_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with push/pop/clear and full/empty/count flags; the head entry is
// presented combinationally (0 while empty) so a consumer can see it before popping.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       clr_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Full/empty are judged on the pre-edge level, so a push into a full FIFO is
    // dropped even if a pop happens on the same edge; clear discards both.
    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem[rptr_q];

endmodule

// File: rtl/spi_regbank.sv
// SPI control/status register bank with TX/RX byte FIFOs between the internal CPU bus
// and the shift engine. Define SPI_REGBANK_IRQ_EN to build CTRL.IRQ_EN and drive irq.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic [31:0] raddr,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        wack,
    output logic        rack,
    output logic        waddrerr,
    output logic        raddrerr,
    output logic        spi_en,
    output logic        cpol,
    output logic        cpha,
    output logic [15:0] clkdiv,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        spi_busy,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    acc_state_e  state_q, state_d;
    logic        en_q, cpol_q, cpha_q, irq_en;
    logic [15:0] clkdiv_q;
    logic        tx_ovf_q, rx_ovf_q, err_q;
    logic [31:0] rdata_q, rd_word, woff, roff;
    logic        do_wr, do_rd, w_ok, r_ok;
    logic        ctrl_wr, status_wr, clkdiv_wr;
    logic        tx_push, tx_pop, tx_clr, tx_full, tx_empty;
    logic        rx_pop, rx_clr, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic        unused_bits;

    // Offsets wrap for addresses below the base, so one unsigned compare covers both ends.
    assign woff = waddr - BASE_ADDR;
    assign roff = raddr - BASE_ADDR;
    assign w_ok = (waddr[1:0] == 2'b00) && (woff < REG_WINDOW)
                  && (woff != OFF_RXDATA) && (woff != OFF_LEVEL);
    assign r_ok = (raddr[1:0] == 2'b00) && (roff < REG_WINDOW) && (roff != OFF_TXDATA);

    assign do_wr = (state_q == ST_IDLE) && wr_en;
    assign do_rd = (state_q == ST_IDLE) && !wr_en && rd_en;

    assign ctrl_wr   = do_wr && w_ok && (woff == OFF_CTRL);
    assign status_wr = do_wr && w_ok && (woff == OFF_STATUS);
    assign clkdiv_wr = do_wr && w_ok && (woff == OFF_CLKDIV);
    assign tx_push   = do_wr && w_ok && (woff == OFF_TXDATA);
    assign tx_clr    = ctrl_wr && wdata[CTRL_TXCLR];
    assign rx_clr    = ctrl_wr && wdata[CTRL_RXCLR];
    assign rx_pop    = do_rd && r_ok && (roff == OFF_RXDATA);
    assign tx_valid  = en_q && !tx_empty;
    assign tx_pop    = tx_valid && tx_ready;

    spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .wdata_i (wdata[7:0]),
        .pop_i   (tx_pop),
        .clr_i   (tx_clr),
        .rdata_o (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_valid),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .clr_i   (rx_clr),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en)      state_d = ST_WACK;
                else if (rd_en) state_d = ST_RACK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        case (roff)
            OFF_CTRL: begin
                rd_word[CTRL_EN]     = en_q;
                rd_word[CTRL_CPOL]   = cpol_q;
                rd_word[CTRL_CPHA]   = cpha_q;
                rd_word[CTRL_IRQ_EN] = irq_en;
            end
            OFF_STATUS: begin
                rd_word[STS_TX_FULL]  = tx_full;
                rd_word[STS_TX_EMPTY] = tx_empty;
                rd_word[STS_RX_FULL]  = rx_full;
                rd_word[STS_RX_EMPTY] = rx_empty;
                rd_word[STS_BUSY]     = spi_busy;
                rd_word[STS_RX_OVF]   = rx_ovf_q;
                rd_word[STS_TX_OVF]   = tx_ovf_q;
            end
            OFF_CLKDIV: rd_word[15:0] = clkdiv_q;
            OFF_RXDATA: rd_word[7:0]  = rx_head;
            OFF_LEVEL: begin
                rd_word[7:0]   = 8'(tx_count);
                rd_word[23:16] = 8'(rx_count);
            end
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            en_q     <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            clkdiv_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_wr)      err_q <= !w_ok;
            else if (do_rd) err_q <= !r_ok;
            if (do_rd) rdata_q <= r_ok ? rd_word : '0;
            if (ctrl_wr) begin
                en_q   <= wdata[CTRL_EN];
                cpol_q <= wdata[CTRL_CPOL];
                cpha_q <= wdata[CTRL_CPHA];
            end
            if (clkdiv_wr) clkdiv_q <= wdata[15:0];
            // A new overflow on the same edge as a write-1-to-clear is kept.
            tx_ovf_q <= (tx_ovf_q && !(status_wr && wdata[STS_TX_OVF])) || (tx_push && tx_full);
            rx_ovf_q <= (rx_ovf_q && !(status_wr && wdata[STS_RX_OVF])) || (rx_valid && rx_full);
        end
    end

`ifdef SPI_REGBANK_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= wdata[CTRL_IRQ_EN];
            irq_q <= irq_en_q && (!rx_empty || rx_ovf_q);
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    assign wack     = (state_q == ST_WACK);
    assign rack     = (state_q == ST_RACK);
    assign waddrerr = wack && err_q;
    assign raddrerr = rack && err_q;
    assign rdata    = rack ? rdata_q : '0;
    assign spi_en   = en_q;
    assign cpol     = cpol_q;
    assign cpha     = cpha_q;
    assign clkdiv   = clkdiv_q;

    assign unused_bits = ^wdata[31:16];

endmodule
